// File: rtl/seq_pkg.sv
// Shared state encoding and opcode constants for the program-counter sequencer.
// Opcodes live in the upper nibble of the fetched instruction byte.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPERAND,
    EXEC,
    HALT
  } seq_state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_CALL = 4'h3;
  localparam logic [3:0] OP_RET  = 4'h4;
  localparam logic [3:0] OP_HLT  = 4'hF;

endpackage

// File: rtl/seq_ret_stack.sv
// LIFO of return addresses for CALL/RET; data shows the current top entry.
// Pushes while full and pops while empty are dropped; the sequencer halts before issuing them.
module seq_ret_stack #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] entries [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign wr_idx = IDX_W'(count);
  assign rd_idx = IDX_W'(count - CNT_W'(1));
  assign data   = entries[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      entries[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer driving an external PC register through pc_next.
// Define SEQ_CALL_EN to add CALL/RET opcodes backed by a return stack.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned STACK_D = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [PC_W-1:0] pc_cur,
  output logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  input  logic            zero_flag,
  output logic            exec_stb,
  output logic [7:0]      exec_op,
  output logic            halted,
  output logic            busy
);

  seq_state_e      state_q, state_d;
  logic [7:0]      ir_q;
  logic [3:0]      opcode;
  logic [PC_W-1:0] pc_inc;

  assign opcode   = ir_q[7:4];
  assign pc_inc   = pc_cur + PC_W'(1);
  // The PC register holds still while a fetch waits, so the address stays stable.
  assign mem_addr = pc_cur;

`ifdef SEQ_CALL_EN
  logic            stk_push;
  logic            stk_pop;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_data;

  seq_ret_stack #(
    .DATA_W(PC_W),
    .DEPTH (STACK_D)
  ) u_ret_stack (
    .clk  (clk),
    .reset(reset),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (pc_inc),
    .data (stk_data),
    .full (stk_full),
    .empty(stk_empty)
  );
`else
  logic unused_stack_d;
  assign unused_stack_d = ^STACK_D;
`endif

  always_comb begin
    state_d = state_q;
    pc_next = pc_cur;
`ifdef SEQ_CALL_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          pc_next = pc_inc;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_NOP:         state_d = FETCH;
          OP_JMP, OP_JZ:  state_d = OPERAND;
`ifdef SEQ_CALL_EN
          OP_CALL:        state_d = stk_full ? HALT : OPERAND;
          OP_RET: begin
            if (stk_empty) begin
              state_d = HALT;
            end else begin
              stk_pop = 1'b1;
              pc_next = stk_data;
              state_d = FETCH;
            end
          end
`endif
          OP_HLT:         state_d = HALT;
          default:        state_d = EXEC;
        endcase
      end
      OPERAND: begin
        if (mem_ack) begin
          state_d = FETCH;
          if (opcode == OP_JZ && !zero_flag) begin
            pc_next = pc_inc;
          end else begin
            pc_next = PC_W'(mem_rdata);
          end
`ifdef SEQ_CALL_EN
          // Return address is the byte after the operand.
          stk_push = (opcode == OP_CALL);
`endif
        end
      end
      EXEC:    state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (reset) pc_next = '0;
  end

  // Outputs are registered from the next state so they change cleanly with the state flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ir_q     <= 8'h00;
      mem_req  <= 1'b0;
      exec_stb <= 1'b0;
      exec_op  <= 8'h00;
      halted   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && mem_ack) begin
        ir_q <= mem_rdata;
      end
      mem_req  <= (state_d == FETCH) || (state_d == OPERAND);
      exec_stb <= (state_d == EXEC);
      exec_op  <= (state_d == EXEC) ? ir_q : 8'h00;
      halted   <= (state_d == HALT);
      busy     <= (state_d != IDLE) && (state_d != HALT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an instruction-level interpreter predicts the stream of
// memory reads, execute pulses and halts; a monitor compares what the DUT actually presents.
module tb_pc_sequencer;

  localparam int PC_W    = 8;
  localparam int STACK_D = 4;
  localparam int EV_MEM  = 0;
  localparam int EV_EXEC = 1;
  localparam int EV_HALT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            run = 1'b0;
  logic [PC_W-1:0] pc_cur;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] mem_addr;
  logic            mem_req;
  logic            mem_ack = 1'b0;
  logic [7:0]      mem_rdata = 8'h00;
  logic            zero_flag = 1'b0;
  logic            exec_stb;
  logic [7:0]      exec_op;
  logic            halted;
  logic            busy;

  pc_sequencer #(
    .PC_W   (PC_W),
    .STACK_D(STACK_D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .pc_cur   (pc_cur),
    .pc_next  (pc_next),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .zero_flag(zero_flag),
    .exec_stb (exec_stb),
    .exec_op  (exec_op),
    .halted   (halted),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // External program counter: reloads pc_next every clock.
  always @(posedge clk) pc_cur <= pc_next;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mem [256];
  bit         zf [1024];
  int         hs_idx = 0;
  int         dly = 0;
  int         dly_min = 0;
  int         dly_max = 0;
  bit         strict = 1'b0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Instruction-level reference: walk the program, one queue entry per observable event.
  task automatic build_expected(input int limit, output bit ends_halt, output logic [7:0] halt_pc);
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] t;
    logic [7:0] stk[$];
    int         n;
    int         cnt;
    pc = 8'h00; n = 0; cnt = 0; ends_halt = 1'b0; halt_pc = 8'h00;
    while (cnt < limit && !ends_halt) begin
      push_ev(EV_MEM, pc); cnt++;
      ir = mem[pc]; n++; pc = pc + 8'd1;
      case (ir[7:4])
        4'h0: ;
        4'h1, 4'h2: begin
          push_ev(EV_MEM, pc); cnt++;
          t = mem[pc];
          if (ir[7:4] == 4'h1 || zf[n]) pc = t;
          else pc = pc + 8'd1;
          n++;
        end
        4'hF: begin
          push_ev(EV_HALT, pc); ends_halt = 1'b1; halt_pc = pc;
        end
`ifdef SEQ_CALL_EN
        4'h3: begin
          if (stk.size() == STACK_D) begin
            push_ev(EV_HALT, pc); ends_halt = 1'b1; halt_pc = pc;
          end else begin
            push_ev(EV_MEM, pc); cnt++;
            t = mem[pc]; n++;
            stk.push_back(pc + 8'd1);
            pc = t;
          end
        end
        4'h4: begin
          if (stk.size() == 0) begin
            push_ev(EV_HALT, pc); ends_halt = 1'b1; halt_pc = pc;
          end else begin
            pc = stk.pop_back();
          end
        end
`endif
        default: begin
          push_ev(EV_EXEC, ir); cnt++;
        end
      endcase
    end
  endtask

  // Memory: random wait states, occasional stray acks while idle, zero_flag tied to handshake index.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (dly == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          zero_flag = zf[hs_idx];
          hs_idx++;
          dly = $urandom_range(dly_max, dly_min);
        end else begin
          mem_ack   = 1'b0;
          zero_flag = 1'($urandom);
          dly--;
        end
      end else begin
        mem_ack   = ($urandom_range(0, 5) == 0);
        mem_rdata = 8'($urandom);
        zero_flag = 1'($urandom);
      end
    end
  end

  task automatic observe(input int kind, input logic [7:0] val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      if (strict) begin
        tests++;
        fails++;
        $display("FAIL unexpected_%s: got 0x%0h, expected no event at %0t", name, val, $time);
      end
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      if (kind == e.kind) check(name, val, e.val);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic       prev_halt = 1'b0;
  logic       prev_stb = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0; prev_ack = 1'b0; prev_halt = 1'b0; prev_stb = 1'b0;
      end else begin
        if (prev_req && !prev_ack) begin
          check("req_held", mem_req, 1);
          check("addr_stable", mem_addr, prev_addr);
        end
        if (mem_req && mem_ack) observe(EV_MEM, mem_addr, "fetch_addr");
        if (exec_stb) begin
          check("stb_one_cycle", prev_stb, 0);
          observe(EV_EXEC, exec_op, "exec_op");
        end
        if (halted && !prev_halt) observe(EV_HALT, pc_cur, "halt_pc");
        prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
        prev_halt = halted; prev_stb = exec_stb;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_pc_next"}, pc_next, 0);
    check({tag, "_pc_cur"}, pc_cur, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_exec_stb"}, exec_stb, 0);
    check({tag, "_exec_op"}, exec_op, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_test(input string tag, input int limit);
    bit         h;
    logic [7:0] hpc;
    int         c;
    reset = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state(tag);
    exp_q.delete();
    build_expected(limit, h, hpc);
    strict = h;
    hs_idx = 0;
    dly = $urandom_range(dly_max, dly_min);
    reset = 1'b0; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    c = 0;
    while (c < 2000 && exp_q.size() > 0) begin
      @(negedge clk);
      run = 1'($urandom);
      c++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d events pending, expected 0", tag, exp_q.size());
    end
    if (h) begin
      repeat (4) @(negedge clk);
      check({tag, "_halted"}, halted, 1);
      check({tag, "_frozen_pc"}, pc_cur, hpc);
      check({tag, "_halt_req"}, mem_req, 0);
      check({tag, "_halt_busy"}, busy, 0);
    end
    run = 1'b0;
    strict = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic fill_zf(input int mode);
    for (int i = 0; i < 1024; i++) zf[i] = (mode == 2) ? 1'($urandom) : (mode == 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    fill_zf(0);

    clear_mem();
    run_test("nops", 6);

    mem[0] = 8'h11; mem[1] = 8'h20;
    run_test("jmp", 8);

    clear_mem();
    mem[5] = 8'h20; mem[6] = 8'h40;
    fill_zf(1);
    run_test("jz_taken", 10);
    fill_zf(0);
    run_test("jz_not_taken", 10);

    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'hFF; mem[8'hFF] = 8'h5A;
    run_test("alu_wrap", 8);

    clear_mem();
    mem[1] = 8'hF0;
    run_test("halt", 10);

    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'h20;
    dly_min = 3; dly_max = 3;
    run_test("slow_mem", 8);

    // Reset in the middle of a waiting fetch.
    exp_q.delete();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    hs_idx = 0; dly = 3;
    reset = 1'b0; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int c = 0; c < 10 && !mem_req; c++) @(negedge clk);
    check("midfetch_req_up", mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midfetch_req_drop", mem_req, 0);
    check("midfetch_busy", busy, 0);
    check("midfetch_pc_next", pc_next, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    strict = 1'b1;
    repeat (6) @(negedge clk);
    check("stale_ack_busy", busy, 0);
    check("stale_ack_req", mem_req, 0);
    check("stale_ack_halted", halted, 0);
    strict = 1'b0;
    dly_min = 0; dly_max = 0;

`ifdef SEQ_CALL_EN
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h10; mem[8'h10] = 8'h30; mem[8'h11] = 8'h30;
    mem[8'h30] = 8'h40; mem[8'h12] = 8'hF0;
    run_test("call_ret", 20);

    clear_mem();
    for (int i = 0; i < 10; i += 2) begin
      mem[i] = 8'h30;
      mem[i + 1] = 8'(i + 2);
    end
    run_test("call_overflow", 20);
`endif

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      fill_zf(2);
      dly_min = 0;
      dly_max = $urandom_range(0, 3);
      run_test("random", 60);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and address width.
REQ-002 SHALL have parameter STACK_D, default 4, meaning return-stack depth (used only with SEQ_CALL_EN).
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports run  input  1  start pulse; pc_cur  input  PC_W  program-counter output.
REQ-006 SHALL have ports pc_next  output  PC_W  program-counter load value; mem_addr  output  PC_W  fetch address.
REQ-007 SHALL have ports mem_req  output  1  fetch request; mem_ack  input  1  fetch done; mem_rdata  input  8  fetched byte.
REQ-008 SHALL have ports zero_flag  input  1  ALU zero; exec_stb  output  1  execute pulse; exec_op  output  8  opcode.
REQ-009 SHALL have ports halted  output  1  halt status; busy  output  1  not IDLE/HALT.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, OPERAND, EXEC, HALT.
REQ-011 SHALL drive pc_next = pc_cur in every cycle without a PC update (hold), since the counter reloads pc_next each clock.
REQ-012 IDLE: run=1 -> FETCH; run ignored in all other states.
REQ-013 FETCH: mem_req=1, mem_addr=pc_cur until mem_ack; on mem_ack latch mem_rdata into IR, pc_next=pc_cur+1, -> DECODE.
REQ-014 mem_req SHALL stay high with mem_addr stable until mem_ack; mem_ack outside FETCH/OPERAND SHALL be ignored.
REQ-015 DECODE: opcode IR[7:4]; 0x0 NOP -> FETCH; 0x1 JMP, 0x2 JZ -> OPERAND; 0xF HLT -> HALT; others -> EXEC.
REQ-016 OPERAND: fetch byte at pc_cur with same handshake; on mem_ack: JMP, or JZ with zero_flag=1 -> pc_next=mem_rdata; JZ with zero_flag=0 -> pc_next=pc_cur+1; -> FETCH.
REQ-017 EXEC: exec_stb=1 for exactly one cycle with exec_op=IR; -> FETCH.
REQ-018 PC arithmetic SHALL wrap modulo 2^PC_W (0xFF+1=0x00).
REQ-019 HALT: halted=1, pc_next holds; left only by reset.
REQ-020 zero_flag SHALL be sampled in the cycle mem_ack is seen in OPERAND.
REQ-021 Minimum instruction time with zero-wait memory: NOP/ALU 2/3 cycles, JMP/JZ 3 cycles.

Reset
REQ-022 reset SHALL asynchronously force IDLE, IR=0x00, mem_req=0, exec_stb=0, exec_op=0x00, halted=0, busy=0, pc_next=0, stack empty.
REQ-023 reset mid-fetch SHALL drop mem_req immediately; a later stale mem_ack SHALL be ignored.

Configuration
REQ-024 Macro SEQ_CALL_EN SHALL enable opcodes 0x3 CALL (2-byte) and 0x4 RET.
REQ-025 With SEQ_CALL_EN: CALL pushes pc_cur+1 (address after operand) then jumps; RET pops into pc_next; push when full or pop when empty -> HALT with halted=1.
REQ-026 Without SEQ_CALL_EN: 0x3/0x4 decode as ALU ops (EXEC); no stack logic synthesised.

Structure
REQ-027 Package seq_pkg SHALL hold the state enum and opcode constants (OP_NOP, OP_JMP, OP_JZ, OP_CALL, OP_RET, OP_HLT).
REQ-028 Return stack SHALL be sub-module seq_ret_stack (push, pop, full, empty, data), instantiated only under SEQ_CALL_EN.

Verification
REQ-029 Reset, run, memory {0x00,0x00}, ack every cycle -> pc_cur 0,1,2; no exec_stb.
REQ-030 Memory {0x11 at 0, 0x20 at 1} -> after operand ack pc_next=0x20; next fetch address 0x20.
REQ-031 JZ at 5 operand 0x40: zero_flag=1 -> pc 0x40; zero_flag=0 -> pc 0x07.
REQ-032 ALU byte 0x5A at 0xFF -> exec_stb one cycle, exec_op=0x5A, pc wraps to 0x00; byte 0xF0 -> halted=1, pc frozen.
REQ-033 mem_ack delayed 3 cycles -> mem_req and mem_addr stable throughout; reset asserted mid-wait -> IDLE, mem_req=0 same cycle.
REQ-034 SEQ_CALL_EN: CALL 0x30 at 0x10, RET at 0x30 -> pc 0x30 then 0x12; five nested CALLs -> halted=1.
